fetch_unit: RTL and testbench

- Front-end instruction fetch stage.
- Owns the fetch PC and issues one 32-bit instruction-memory read at a time.
- Pushes each returned instruction word, tagged with its PC, into the downstream instruction queue.
- Handles queue back-pressure by buffering one response, and handles backend redirects (branch mispredict / flush) by discarding stale in-flight fetches.

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one imem read in
// flight, forwards returned words (tagged with their PC) to the instruction
// queue, buffers one word under back-pressure and squashes stale fetches on
// backend redirects.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h1eceb000)
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr_o,
  output logic [3:0]      imem_rmask_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            imem_resp_i,
  input  logic            iq_full_i,
  output logic            iq_push_o,
  output logic [XLEN-1:0] iq_instr_o,
  output logic [XLEN-1:0] iq_pc_o,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StDrain} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;

  logic [XLEN-1:0] redir_pc;
  logic [XLEN-1:0] pc_inc;
  logic            unused_redir_lsbs;

  // Redirect targets are forced word aligned; the low bits are don't-care.
  assign redir_pc          = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_redir_lsbs = ^redirect_pc_i[1:0];
  assign pc_inc            = pc_q + XLEN'(4);
  assign imem_addr_o       = pc_q;

  // Next-state and output decode; redirect outranks every other event.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    imem_rmask_o = 4'h0;
    iq_push_o    = 1'b0;
    iq_instr_o   = '0;
    iq_pc_o      = '0;

    unique case (state_q)
      StReq: begin
        if (redirect_valid_i) begin
          pc_d = redir_pc;
        end else begin
          imem_rmask_o = 4'hf;
          state_d      = StWait;
        end
      end
      StWait: begin
        if (redirect_valid_i) begin
          // Response (if any) in this cycle belongs to the old path.
          pc_d    = redir_pc;
          state_d = imem_resp_i ? StReq : StDrain;
        end else if (imem_resp_i) begin
          pc_d = pc_inc;
          if (!iq_full_i) begin
            iq_push_o  = 1'b1;
            iq_instr_o = imem_rdata_i;
            iq_pc_o    = pc_q;
            state_d    = StReq;
          end else begin
            hold_instr_d = imem_rdata_i;
            hold_pc_d    = pc_q;
            state_d      = StHold;
          end
        end
      end
      StHold: begin
        if (redirect_valid_i) begin
          pc_d    = redir_pc;
          state_d = StReq;
        end else if (!iq_full_i) begin
          iq_push_o  = 1'b1;
          iq_instr_o = hold_instr_q;
          iq_pc_o    = hold_pc_q;
          state_d    = StReq;
        end
      end
      StDrain: begin
        // Waiting out a stale response; the latest redirect target wins.
        if (redirect_valid_i) begin
          pc_d = redir_pc;
        end
        if (imem_resp_i) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase

    // Outputs are quiet while reset is held, whatever the current state.
    if (rst) begin
      imem_rmask_o = 4'h0;
      iq_push_o    = 1'b0;
      iq_instr_o   = '0;
      iq_pc_o      = '0;
    end
  end

  // State, PC and hold-buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-programmable memory model, a
// reference model of which responses must reach the queue, and a scoreboard
// of expected pushes compared against the DUT's push port every cycle.
module tb_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h1eceb000;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        iq_full;
  logic        iq_push;
  logic [31:0] iq_instr;
  logic [31:0] iq_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  fetch_unit #(
    .XLEN    (32),
    .RESET_PC(ResetPc)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr_o     (imem_addr),
    .imem_rmask_o    (imem_rmask),
    .imem_rdata_i    (imem_rdata),
    .imem_resp_i     (imem_resp),
    .iq_full_i       (iq_full),
    .iq_push_o       (iq_push),
    .iq_instr_o      (iq_instr),
    .iq_pc_o         (iq_pc),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] req_addr_log[$];
  int          req_cyc_log[$];

  int          n_vec, n_err;
  int          cyc, push_count, mem_lat, mem_cnt;
  logic        mem_pend, stale, held_v, last_push;
  logic [31:0] mem_addr, held_pc, held_instr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: evaluate model and check outputs at negedge, then
  // advance the memory model just after the rising edge.
  task automatic tick();
    logic        req_now;
    logic [31:0] req_a;
    ent_t        e;
    req_now = 1'b0;
    req_a   = '0;
    @(negedge clk);
    if (rst) begin
      held_v = 1'b0;
      stale  = 1'b0;
      check_val("rmask_rst", 32'(imem_rmask), 32'h0);
    end else begin
      if (imem_resp) begin
        if (!stale && !redirect_valid) begin
          held_v     = 1'b1;
          held_pc    = mem_addr;
          held_instr = imem_rdata;
        end
        stale = 1'b0;
      end
      if (redirect_valid) begin
        held_v = 1'b0;
        if (mem_pend) stale = 1'b1;
      end
      if (held_v && !iq_full && !redirect_valid) begin
        e.pc    = held_pc;
        e.instr = held_instr;
        sb.push_back(e);
        held_v = 1'b0;
      end
      if (imem_rmask == 4'hf) begin
        check_val("one_outstanding", 32'(mem_pend), 32'h0);
        req_now = 1'b1;
        req_a   = imem_addr;
        req_addr_log.push_back(imem_addr);
        req_cyc_log.push_back(cyc);
      end else begin
        check_val("rmask_idle", 32'(imem_rmask), 32'h0);
      end
    end
    check_val("push_while_full", 32'(iq_push & iq_full), 32'h0);
    check_val("push", 32'(iq_push), 32'(sb.size() != 0));
    if (iq_push && sb.size() != 0) begin
      e = sb.pop_front();
      check_val("push_pc", iq_pc, e.pc);
      check_val("push_instr", iq_instr, e.instr);
      push_count++;
    end else if (!iq_push) begin
      check_val("idle_pc", iq_pc, 32'h0);
      check_val("idle_instr", iq_instr, 32'h0);
    end
    last_push = iq_push;
    @(posedge clk);
    #1;
    cyc++;
    imem_resp  = 1'b0;
    imem_rdata = 32'hdeadbeef;
    if (rst) begin
      mem_pend = 1'b0;
    end else if (req_now) begin
      mem_pend = 1'b1;
      mem_cnt  = mem_lat;
      mem_addr = req_a;
    end else if (mem_pend) begin
      mem_cnt--;
    end
    if (mem_pend && mem_cnt == 1) begin
      imem_resp  = 1'b1;
      imem_rdata = mem_addr ^ 32'h00000013;
      mem_pend   = 1'b0;
    end
  endtask

  task automatic do_reset(input int lat);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    iq_full        = 1'b0;
    tick();
    tick();
    check_val("rst_addr", imem_addr, ResetPc);
    check_val("rst_push", 32'(last_push), 32'h0);
    rst     = 1'b0;
    mem_lat = lat;
    sb.delete();
    req_addr_log.delete();
    req_cyc_log.delete();
    cyc        = 0;
    push_count = 0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; push_count = 0; mem_lat = 1; mem_cnt = 0;
    mem_pend = 1'b0; stale = 1'b0; held_v = 1'b0; last_push = 1'b0;
    mem_addr = '0; held_pc = '0; held_instr = '0;
    rst = 1'b1; imem_resp = 1'b0; imem_rdata = 32'hdeadbeef;
    iq_full = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Streaming with a 1-cycle memory: one push every second cycle.
    do_reset(1);
    repeat (6) tick();
    check_val("t1_nreq", req_addr_log.size(), 3);
    check_val("t1_req0", req_addr_log[0], 32'h1eceb000);
    check_val("t1_req1", req_addr_log[1], 32'h1eceb004);
    check_val("t1_req2", req_addr_log[2], 32'h1eceb008);
    check_val("t1_cyc0", req_cyc_log[0], 0);
    check_val("t1_cyc2", req_cyc_log[2], 4);
    check_val("t1_npush", push_count, 3);

    // Back-pressure: queue full for three cycles when 1eceb004 returns.
    do_reset(1);
    repeat (3) tick();
    iq_full = 1'b1;
    tick();
    check_val("t2_no_push_full", 32'(last_push), 32'h0);
    repeat (2) tick();
    iq_full = 1'b0;
    tick();
    check_val("t2_push_release", 32'(last_push), 32'h1);
    tick();
    check_val("t2_nreq", req_addr_log.size(), 3);
    check_val("t2_req2", req_addr_log[2], 32'h1eceb008);
    check_val("t2_cyc2", req_cyc_log[2], 7);

    // Redirect during WAIT with latency 5: stale response is dropped.
    do_reset(5);
    repeat (2) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1eceb100;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    check_val("t3_no_stale_push", push_count, 0);
    tick();
    check_val("t3_req1", req_addr_log[1], 32'h1eceb100);
    check_val("t3_cyc1", req_cyc_log[1], 6);
    repeat (5) tick();
    check_val("t3_npush", push_count, 1);

    // Redirect coinciding with the response.
    do_reset(1);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1eceb180;
    tick();
    check_val("t4_no_push", 32'(last_push), 32'h0);
    redirect_valid = 1'b0;
    tick();
    check_val("t4_req1", req_addr_log[1], 32'h1eceb180);
    check_val("t4_cyc1", req_cyc_log[1], 2);
    tick();
    check_val("t4_npush", push_count, 1);

    // Two redirects while draining; the latest (unaligned) target wins.
    do_reset(4);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1eceb200;
    tick();
    redirect_pc    = 32'h1eceb303;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    check_val("t5_npush", push_count, 0);
    check_val("t5_req1", req_addr_log[1], 32'h1eceb300);
    check_val("t5_cyc1", req_cyc_log[1], 5);

    // PC wrap at the top of memory, then reset while holding a word.
    do_reset(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hfffffffc;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    check_val("t6_req0", req_addr_log[0], 32'hfffffffc);
    check_val("t6_req1", req_addr_log[1], 32'h00000000);
    check_val("t6_npush", push_count, 1);
    iq_full = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_val("t6_rst_push", 32'(last_push), 32'h0);
    rst     = 1'b0;
    iq_full = 1'b0;
    tick();
    check_val("t6_restart", req_addr_log[req_addr_log.size()-1], ResetPc);
    tick();
    check_val("t6_npush_after", push_count, 2);
    check_val("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
